// File: rtl/bram2_be_clr.sv
// True dual-port RAM with lane write enables, selectable read-during-write behaviour,
// optional output pipeline, post-reset zero-fill and same-address collision flag.
module bram2_be_clr #(
  parameter int PIPELINED      = 0,
  parameter int ADDR_WIDTH     = 1,
  parameter int DATA_WIDTH     = 8,
  parameter int CHUNKSIZE      = 8,
  parameter int WE_WIDTH       = DATA_WIDTH / CHUNKSIZE,
  parameter int MEMSIZE        = 2,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ENA,
  input  logic [WE_WIDTH-1:0]   WEA,
  input  logic [ADDR_WIDTH-1:0] ADDRA,
  input  logic [DATA_WIDTH-1:0] DIA,
  output logic [DATA_WIDTH-1:0] DOA,
  output logic                  DOA_VALID,
  input  logic                  ENB,
  input  logic [WE_WIDTH-1:0]   WEB,
  input  logic [ADDR_WIDTH-1:0] ADDRB,
  input  logic [DATA_WIDTH-1:0] DIB,
  output logic [DATA_WIDTH-1:0] DOB,
  output logic                  DOB_VALID,
  output logic                  READY,
  output logic                  COLLISION
);

  localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [ADDR_WIDTH:0]   MEM_LIM  = (ADDR_WIDTH+1)'(MEMSIZE);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(MEMSIZE - 1);

  generate
    if ((DATA_WIDTH % CHUNKSIZE) != 0 || (WE_WIDTH * CHUNKSIZE) != DATA_WIDTH) begin : g_bad_chunk
      $error("bram2_be_clr: DATA_WIDTH must be WE_WIDTH * CHUNKSIZE");
    end
    if (MEMSIZE > (2 ** ADDR_WIDTH) || MEMSIZE < 1) begin : g_bad_size
      $error("bram2_be_clr: MEMSIZE must be in 1..2**ADDR_WIDTH");
    end
  endgenerate

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  clear_we;
  logic                  ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clear_we   = 1'b0;
    ready      = 1'b0;
    case (state_reg)
      S_CLEAR: begin
        clear_we = 1'b1;
        cnt_next = cnt_reg + ADDR_WIDTH'(1);
        if (cnt_reg == CNT_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end
      end
      S_RUN:   ready = 1'b1;
      default: state_next = RESET_STATE;
    endcase
  end

  assign READY = ready;

  // Access qualification
  logic             acc_a, acc_b, wr_a, wr_b, in_a, in_b, same_addr;
  logic [IDX_W-1:0] idx_a, idx_b, cnt_idx;

  assign acc_a     = ENA && ready;
  assign acc_b     = ENB && ready;
  assign wr_a      = acc_a && (|WEA);
  assign wr_b      = acc_b && (|WEB);
  assign in_a      = {1'b0, ADDRA} < MEM_LIM;
  assign in_b      = {1'b0, ADDRB} < MEM_LIM;
  assign idx_a     = ADDRA[IDX_W-1:0];
  assign idx_b     = ADDRB[IDX_W-1:0];
  assign cnt_idx   = cnt_reg[IDX_W-1:0];
  assign same_addr = acc_a && acc_b && (ADDRA == ADDRB);

  logic [DATA_WIDTH-1:0] mem [0:MEMSIZE-1];
  logic [DATA_WIDTH-1:0] old_a, old_b;

  assign old_a = in_a ? mem[idx_a] : '0;
  assign old_b = in_b ? mem[idx_b] : '0;

  // Post-write word seen by each port; on a shared address port A owns overlapping lanes.
  logic [DATA_WIDTH-1:0] final_a, final_b;
  logic [WE_WIDTH-1:0]   lane_wr_a, lane_wr_b, lane_commit_b;

  genvar gi;
  generate
    for (gi = 0; gi < WE_WIDTH; gi++) begin : g_lane
      localparam int LO = gi * CHUNKSIZE;
      assign lane_wr_a[gi]     = wr_a && WEA[gi];
      assign lane_wr_b[gi]     = wr_b && WEB[gi];
      assign lane_commit_b[gi] = lane_wr_b[gi] && !(same_addr && lane_wr_a[gi]);
      assign final_a[LO +: CHUNKSIZE] =
        lane_wr_a[gi]                ? DIA[LO +: CHUNKSIZE] :
        (same_addr && lane_wr_b[gi]) ? DIB[LO +: CHUNKSIZE] : old_a[LO +: CHUNKSIZE];
      assign final_b[LO +: CHUNKSIZE] =
        (same_addr && lane_wr_a[gi]) ? DIA[LO +: CHUNKSIZE] :
        lane_wr_b[gi]                ? DIB[LO +: CHUNKSIZE] : old_b[LO +: CHUNKSIZE];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (clear_we) begin
      mem[cnt_idx] <= '0;
    end else begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        if (lane_commit_b[i] && in_b)
          mem[idx_b][i*CHUNKSIZE +: CHUNKSIZE] <= DIB[i*CHUNKSIZE +: CHUNKSIZE];
        if (lane_wr_a[i] && in_a)
          mem[idx_a][i*CHUNKSIZE +: CHUNKSIZE] <= DIA[i*CHUNKSIZE +: CHUNKSIZE];
      end
    end
  end

  // Returns {valid, data}; a reading port always sees the pre-write word.
  function automatic logic [DATA_WIDTH:0] stage1_next(
    input logic                  acc,
    input logic                  wr,
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] merged_w,
    input logic [DATA_WIDTH-1:0] hold_w
  );
    logic [DATA_WIDTH:0] r;
    r = {1'b0, hold_w};
    if (acc) begin
      if (!wr)                  r = {1'b1, old_w};
      else if (WRITE_MODE == 0) r = {1'b1, merged_w};
      else if (WRITE_MODE == 1) r = {1'b1, old_w};
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] doa1_reg, dob1_reg, doa1_next, dob1_next;
  logic                  va1_reg, vb1_reg, va1_next, vb1_next;
  logic                  collision_reg;

  always_comb begin
    {va1_next, doa1_next} = stage1_next(acc_a, wr_a, old_a, final_a, doa1_reg);
    {vb1_next, dob1_next} = stage1_next(acc_b, wr_b, old_b, final_b, dob1_reg);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      doa1_reg      <= '0;
      dob1_reg      <= '0;
      va1_reg       <= 1'b0;
      vb1_reg       <= 1'b0;
      collision_reg <= 1'b0;
    end else begin
      doa1_reg      <= doa1_next;
      dob1_reg      <= dob1_next;
      va1_reg       <= va1_next;
      vb1_reg       <= vb1_next;
      collision_reg <= same_addr && (wr_a || wr_b);
    end
  end

  assign COLLISION = collision_reg;

  generate
    if (PIPELINED != 0) begin : g_pipe
      logic [DATA_WIDTH-1:0] doa2_reg, dob2_reg;
      logic                  va2_reg, vb2_reg;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          doa2_reg <= '0;
          dob2_reg <= '0;
          va2_reg  <= 1'b0;
          vb2_reg  <= 1'b0;
        end else begin
          doa2_reg <= doa1_reg;
          dob2_reg <= dob1_reg;
          va2_reg  <= va1_reg;
          vb2_reg  <= vb1_reg;
        end
      end

      assign DOA       = doa2_reg;
      assign DOB       = dob2_reg;
      assign DOA_VALID = va2_reg;
      assign DOB_VALID = vb2_reg;
    end else begin : g_nopipe
      assign DOA       = doa1_reg;
      assign DOB       = dob1_reg;
      assign DOA_VALID = va1_reg;
      assign DOB_VALID = vb1_reg;
    end
  endgenerate

endmodule

// File: tb/tb_bram2_be_clr.sv
// Drives three bram2_be_clr variants (write-first, read-first pipelined, no-change)
// with identical stimulus and checks them against a behavioural memory model.
module tb_bram2_be_clr;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CS = 8;
  localparam int WW = 4;
  localparam int MS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ena = 1'b0, enb = 1'b0;
  logic [WW-1:0] wea = '0, web = '0;
  logic [AW-1:0] addra = '0, addrb = '0;
  logic [DW-1:0] dia = '0, dib = '0;

  logic [2:0][DW-1:0] doa, dob;
  logic [2:0]         va, vb, rdy, coll;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      bram2_be_clr #(
        .PIPELINED(gi == 1 ? 1 : 0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHUNKSIZE(CS),
        .WE_WIDTH(WW), .MEMSIZE(MS), .WRITE_MODE(gi), .CLEAR_ON_RESET(1)
      ) u_dut (
        .CLK(clk), .RST_N(rst_n),
        .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[gi]), .DOA_VALID(va[gi]),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[gi]), .DOB_VALID(vb[gi]),
        .READY(rdy[gi]), .COLLISION(coll[gi])
      );
    end
  endgenerate

  typedef struct packed {logic [DW-1:0] d; logic v; logic dc;} pe_t;
  typedef struct packed {pe_t a; pe_t b;} exp_t;

  exp_t          q0[$], q1[$], q2[$];
  exp_t          hold_m [3];
  logic [DW-1:0] m_mem [MS];
  bit            m_ready;
  int            clr;
  int            checks = 0;
  int            failures = 0;
  int            step_no = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic pe_t port_model(input int mode, input pe_t h, input bit acc, input bit wr,
                                     input bit inr, input logic [DW-1:0] oldw, input logic [DW-1:0] finw);
    pe_t r;
    r = h;
    r.v = 1'b0;
    if (acc) begin
      if (!wr || mode == 1) begin
        r.d = oldw; r.v = 1'b1; r.dc = !inr;
      end else if (mode == 0) begin
        r.d = finw; r.v = 1'b1; r.dc = !inr;
      end
    end
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_dut%0d_doa", tag, d), doa[d], '0);
      chk($sformatf("%s_dut%0d_va", tag, d), DW'(va[d]), '0);
      chk($sformatf("%s_dut%0d_dob", tag, d), dob[d], '0);
      chk($sformatf("%s_dut%0d_vb", tag, d), DW'(vb[d]), '0);
      chk($sformatf("%s_dut%0d_ready", tag, d), DW'(rdy[d]), '0);
      chk($sformatf("%s_dut%0d_coll", tag, d), DW'(coll[d]), '0);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    #1;
    check_all_zero("rst_async");
    m_ready = 1'b0;
    clr = 0;
    for (int d = 0; d < 3; d++) hold_m[d] = '0;
    q0.delete(); q1.delete(); q2.delete();
    q1.push_back('0);
    repeat (cycles) @(posedge clk);
    #1;
    check_all_zero("rst_held");
    $display("reset released after %0d cycles", cycles);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit ea, input logic [WW-1:0] wa_, input logic [AW-1:0] aa, input logic [DW-1:0] da_,
                      input bit eb, input logic [WW-1:0] wb_, input logic [AW-1:0] ab, input logic [DW-1:0] db_);
    logic [DW-1:0] nxt [MS];
    logic [DW-1:0] oa, ob, fa, fb;
    bit acca, accb, wra, wrb, ina, inb, exp_coll;
    exp_t e;
    ena = ea; wea = wa_; addra = aa; dia = da_;
    enb = eb; web = wb_; addrb = ab; dib = db_;
    acca = ea && m_ready;
    accb = eb && m_ready;
    wra = acca && (wa_ != '0);
    wrb = accb && (wb_ != '0);
    ina = int'(aa) < MS;
    inb = int'(ab) < MS;
    oa = ina ? m_mem[aa[3:0]] : 'x;
    ob = inb ? m_mem[ab[3:0]] : 'x;
    nxt = m_mem;
    if (wrb && inb)
      for (int l = 0; l < WW; l++) if (wb_[l]) nxt[ab[3:0]][l*CS +: CS] = db_[l*CS +: CS];
    if (wra && ina)
      for (int l = 0; l < WW; l++) if (wa_[l]) nxt[aa[3:0]][l*CS +: CS] = da_[l*CS +: CS];
    fa = ina ? nxt[aa[3:0]] : 'x;
    fb = inb ? nxt[ab[3:0]] : 'x;
    exp_coll = acca && accb && (aa == ab) && (wra || wrb);
    for (int d = 0; d < 3; d++) begin
      hold_m[d].a = port_model(d, hold_m[d].a, acca, wra, ina, oa, fa);
      hold_m[d].b = port_model(d, hold_m[d].b, accb, wrb, inb, ob, fb);
    end
    q0.push_back(hold_m[0]);
    q1.push_back(hold_m[1]);
    q2.push_back(hold_m[2]);
    @(posedge clk);
    #1;
    m_mem = nxt;
    if (!m_ready) begin
      m_mem[clr] = '0;
      clr++;
      if (clr == MS) m_ready = 1'b1;
    end
    step_no++;
    $display("step %0d A en=%0b we=%h ad=%0d di=%h | B en=%0b we=%h ad=%0d di=%h | doa0=%h dob0=%h ready=%0b",
             step_no, ea, wa_, aa, da_, eb, wb_, ab, db_, doa[0], dob[0], rdy[0]);
    for (int d = 0; d < 3; d++) begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      if (!e.a.dc) chk($sformatf("s%0d_dut%0d_doa", step_no, d), doa[d], e.a.d);
      chk($sformatf("s%0d_dut%0d_va", step_no, d), DW'(va[d]), DW'(e.a.v));
      if (!e.b.dc) chk($sformatf("s%0d_dut%0d_dob", step_no, d), dob[d], e.b.d);
      chk($sformatf("s%0d_dut%0d_vb", step_no, d), DW'(vb[d]), DW'(e.b.v));
      chk($sformatf("s%0d_dut%0d_coll", step_no, d), DW'(coll[d]), DW'(exp_coll));
      chk($sformatf("s%0d_dut%0d_ready", step_no, d), DW'(rdy[d]), DW'(m_ready));
    end
  endtask

  task automatic idle();
    step(0, '0, '0, '0, 0, '0, '0, '0);
  endtask

  task automatic wr_a(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [WW-1:0] we);
    step(1, we, ad, d, 0, '0, '0, '0);
  endtask

  task automatic rd_a(input logic [AW-1:0] ad);
    step(1, '0, ad, '0, 0, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < MS; i++) m_mem[i] = 'x;
    #2;
    do_reset(3);
    // Accesses during the clear must be ignored; reset again at cnt=9
    for (int i = 0; i < 9; i++) step(1, '0, AW'(i), '0, 1, 4'hF, AW'(i), 32'hFFFF_FFFF);
    do_reset(2);
    for (int i = 0; i < MS; i++) step(1, 4'hF, AW'(i), 32'h5A5A_5A5A, 0, '0, '0, '0);
    // Full sweep of cleared memory on both ports
    for (int i = 0; i < MS; i++) step(1, '0, AW'(i), '0, 1, '0, AW'(MS - 1 - i), '0);
    idle();
    // Lane enables
    wr_a(5'd3, 32'hAABB_CCDD, 4'hF);
    wr_a(5'd3, 32'h1122_3344, 4'b0101);
    rd_a(5'd3);
    // Read-during-write per mode
    wr_a(5'd5, 32'h0000_000F, 4'hF);
    wr_a(5'd5, 32'h0000_00F0, 4'hF);
    idle();
    rd_a(5'd5);
    // Collisions
    step(1, 4'hF, 5'd7, 32'h0000_0055, 1, 4'hF, 5'd7, 32'h0000_0066);
    step(1, '0, 5'd7, '0, 1, '0, 5'd7, '0);
    step(1, 4'b0001, 5'd8, 32'h0000_00AA, 1, 4'b0011, 5'd8, 32'h0000_BBBB);
    rd_a(5'd8);
    step(1, 4'hF, 5'd7, 32'h0000_0077, 1, '0, 5'd7, '0);
    step(1, '0, 5'd9, '0, 1, 4'hF, 5'd9, 32'h0000_0099);
    step(1, '0, 5'd9, '0, 1, '0, 5'd7, '0);
    // Out-of-range write must not alias into a low address
    wr_a(5'd4, 32'h1234_5678, 4'hF);
    wr_a(5'd20, 32'hDEAD_BEEF, 4'hF);
    rd_a(5'd4);
    // Randomised dual-port traffic on a small address window
    for (int i = 0; i < 40; i++) begin
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? WW'($urandom) : '0,
           AW'($urandom_range(0, 3)), $urandom,
           bit'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? WW'($urandom) : '0,
           AW'($urandom_range(0, 3)), $urandom);
    end
    // Reset with a pipelined read in flight, then confirm memory is cleared again
    rd_a(5'd3);
    do_reset(1);
    for (int i = 0; i < MS; i++) idle();
    rd_a(5'd3);
    step(1, '0, 5'd5, '0, 1, '0, 5'd7, '0);
    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram2_be_clr.md
# bram2_be_clr

Single-clock true dual-port block RAM with per-lane write enables, a selectable read-during-write mode, an optional output pipeline stage, and registered read-valid flags. It adds an automatic post-reset clear sequencer and same-address collision detection. It is the successor to the basic dual-port BRAM primitive, for Verilog-backend memories that need partial writes, a known post-reset content, and flagged data validity.

## Interface
- PIPELINED, 0: 1 adds a second output register stage; read latency becomes 2.
- ADDR_WIDTH, 1: address width.
- DATA_WIDTH, 8: word width.
- CHUNKSIZE, 8: bits per write-enable lane; DATA_WIDTH must be a multiple of it, otherwise elaboration fails.
- WE_WIDTH, DATA_WIDTH/CHUNKSIZE: number of write-enable lanes.
- MEMSIZE, 2: number of words, at most 2**ADDR_WIDTH.
- WRITE_MODE, 0: 0 = write-first, 1 = read-first, 2 = no-change.
- CLEAR_ON_RESET, 1: 1 = zero-fill the memory after reset.

Ports:
- CLK in 1: the single clock.
- RST_N in 1: reset, asynchronous, active-low.
- ENA in 1: port A access enable.
- WEA in WE_WIDTH: port A per-lane write enable.
- ADDRA in ADDR_WIDTH: port A address.
- DIA in DATA_WIDTH: port A write data.
- DOA out DATA_WIDTH: port A read data.
- DOA_VALID out 1: DOA holds the result of a new access this cycle.
- ENB, WEB, ADDRB, DIB, DOB, DOB_VALID: same as port A, for port B.
- READY out 1: the block accepts accesses.
- COLLISION out 1: one-cycle pulse flagging a same-address conflict.

## Operation
- Lane i is bits [i*CHUNKSIZE +: CHUNKSIZE]. An access is "accepted" when EN=1 and READY=1. An accepted access with WE all-zero is a read; with any WE bit set it is a write of the enabled lanes only.
- The RAM array itself is not reset. Only the control state, counter, output registers, valid flags and COLLISION are reset.
- Clear sequencer states:
  - CLEAR: writes 0 to RAM[cnt] each cycle and increments cnt. After writing MEMSIZE-1 it moves to RUN.
  - RUN: READY=1.
  - Reset enters CLEAR with cnt=0 when CLEAR_ON_RESET=1, otherwise enters RUN directly.
- While READY=0, port inputs are ignored: no RAM write, no output update, valid flags stay 0.
- Output on an accepted access (stage-1 register):
  - Write-first: DO gets the merged word (new data in enabled lanes, old data in the others).
  - Read-first: DO gets the old word.
  - No-change write: DO holds its value and DO_VALID stays 0 for that access.
  - Read: DO gets RAM[addr].
- DO holds its value between accesses. DO_VALID is 1 for exactly one cycle per accepted access that updates DO.
- Collision: both ports accepted, ADDRA==ADDRB, and at least one is writing.
  - Lanes written by both ports: port A data wins.
  - A port that is only reading returns the pre-write word, regardless of WRITE_MODE.
  - A writing port follows its own WRITE_MODE, using the final merged word.
  - COLLISION is registered: it pulses 1 in the cycle after the conflict. Two reads to the same address are not a collision.
- Out-of-range addresses (≥ MEMSIZE): writes are dropped, reads return an undefined value, and DO_VALID still asserts.

## Timing
- Reset values: DOA=DOB=0, DOA_VALID=DOB_VALID=0, COLLISION=0. READY is 0 when CLEAR_ON_RESET=1, and 1 when CLEAR_ON_RESET=0.
- Clear takes exactly MEMSIZE cycles. READY rises on the edge after the final clear write, i.e. the MEMSIZE-th rising edge after RST_N deasserts.
- Read latency: data and valid appear on the edge after the accepted access (PIPELINED=0), or two edges after (PIPELINED=1). Stage 2 copies DO/valid from stage 1 every cycle.
- Back-to-back accesses are accepted every cycle on both ports, with no bubbles.
- RST_N asserted mid-clear or mid-access immediately forces all reset values and restarts the clear from address 0. An in-flight pipelined result is discarded.

## Test plan
- MEMSIZE=16, CLEAR_ON_RESET=1 -> READY=0 for 16 cycles after RST_N rises; then reading all 16 addresses returns 0, with DOA_VALID pulsing one cycle after each read.
- DATA_WIDTH=32, CHUNKSIZE=8: write 0xAABBCCDD to address 3, then write 0x11223344 with WEA=4'b0101 -> a read of address 3 returns 0xAA22CC44.
- WRITE_MODE 0/1/2: address 5 holds 0x0F, write 0xF0 -> DOA is 0xF0 (write-first), 0x0F (read-first), or held with DOA_VALID=0 (no-change).
- Same cycle, port A writes 0x55 and port B writes 0x66 to address 7 -> RAM[7]=0x55 and COLLISION=1 next cycle. Port A write plus port B read of the same address -> DOB is the old value and COLLISION=1.
- PIPELINED=1: a read issued at cycle t -> DOA/DOA_VALID update at t+2. Continuous reads produce one valid result per cycle.
- Assert RST_N low during the clear at cnt=9, then release -> READY stays 0 for a full MEMSIZE cycles, outputs are 0, and no valid pulses occur.
